// File: rtl/regfile_scoreboard_if.sv
// Register-file / scoreboard bus: decode-side reads and reservations,
// writeback-side writes. master = CPU pipeline, slave = register file.
interface regfile_scoreboard_if #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 5
);
    logic [ADDR_BITS-1:0] ReadRegister1;
    logic [ADDR_BITS-1:0] ReadRegister2;
    logic [WIDTH-1:0]     ReadData1;
    logic [WIDTH-1:0]     ReadData2;
    logic                 ReadBusy1;
    logic                 ReadBusy2;
    logic [ADDR_BITS-1:0] WriteRegister0;
    logic [ADDR_BITS-1:0] WriteRegister1;
    logic [WIDTH-1:0]     WriteData0;
    logic [WIDTH-1:0]     WriteData1;
    logic                 RegWrite0;
    logic                 RegWrite1;
    logic                 Reserve;
    logic [ADDR_BITS-1:0] ReserveRegister;
    logic                 ReserveStall;
    logic [ADDR_BITS:0]   BusyCount;

    modport master (
        output ReadRegister1, ReadRegister2,
        output WriteRegister0, WriteRegister1, WriteData0, WriteData1,
        output RegWrite0, RegWrite1, Reserve, ReserveRegister,
        input  ReadData1, ReadData2, ReadBusy1, ReadBusy2,
        input  ReserveStall, BusyCount
    );

    modport slave (
        input  ReadRegister1, ReadRegister2,
        input  WriteRegister0, WriteRegister1, WriteData0, WriteData1,
        input  RegWrite0, RegWrite1, Reserve, ReserveRegister,
        output ReadData1, ReadData2, ReadBusy1, ReadBusy2,
        output ReserveStall, BusyCount
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// MIPS-style register file (2 async read, 2 sync write, r0 = 0) with a
// per-register busy scoreboard: issue reserves a destination, writeback
// releases it. Optional same-cycle write->read forwarding is enabled by
// defining REGFILE_BYPASS_EN.
module regfile_scoreboard #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 5
) (
    input logic                 Clk,
    input logic                 Reset_n,
    regfile_scoreboard_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_BITS;

    logic [DEPTH-1:0][WIDTH-1:0] regs;
    logic [DEPTH-1:0]            busy;
    logic [DEPTH-1:0]            busyNext;
    logic [ADDR_BITS:0]          busyCount;
    logic [ADDR_BITS:0]          busyCountNext;
    logic                        releasing;
    logic                        reserveStall;
    logic                        reserveGrant;

    // A writeback to the requested register this cycle frees it, so no stall.
    always_comb begin
        releasing = (bus.RegWrite0 && bus.WriteRegister0 == bus.ReserveRegister) ||
                    (bus.RegWrite1 && bus.WriteRegister1 == bus.ReserveRegister);
    end

    // busy[0] is never set, so a reserve of r0 never stalls.
    assign reserveStall = bus.Reserve & busy[bus.ReserveRegister] & ~releasing;
    assign reserveGrant = bus.Reserve & ~reserveStall & (bus.ReserveRegister != '0);

    // Next busy vector: writes release, a granted reserve sets (reserve wins).
    always_comb begin
        busyNext = busy;
        for (int i = 1; i < DEPTH; i++) begin
            if ((bus.RegWrite0 && bus.WriteRegister0 == ADDR_BITS'(i)) ||
                (bus.RegWrite1 && bus.WriteRegister1 == ADDR_BITS'(i)))
                busyNext[i] = 1'b0;
            if (reserveGrant && bus.ReserveRegister == ADDR_BITS'(i))
                busyNext[i] = 1'b1;
        end
        busyNext[0] = 1'b0;
    end

    // Popcount of the next busy vector, registered alongside it.
    always_comb begin
        busyCountNext = '0;
        for (int i = 1; i < DEPTH; i++)
            busyCountNext = busyCountNext + {{ADDR_BITS{1'b0}}, busyNext[i]};
    end

    // Register array, scoreboard and count; port 1 wins a same-address write.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            regs      <= '0;
            busy      <= '0;
            busyCount <= '0;
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (bus.RegWrite1 && bus.WriteRegister1 == ADDR_BITS'(i))
                    regs[i] <= bus.WriteData1;
                else if (bus.RegWrite0 && bus.WriteRegister0 == ADDR_BITS'(i))
                    regs[i] <= bus.WriteData0;
            end
            busy      <= busyNext;
            busyCount <= busyCountNext;
        end
    end

    // Read port 1: stored value (optionally forwarded from a same-cycle write).
    always_comb begin
        bus.ReadData1 = regs[bus.ReadRegister1];
        bus.ReadBusy1 = busy[bus.ReadRegister1];
`ifdef REGFILE_BYPASS_EN
        // Forwarding is suppressed in reset since no write can complete then.
        if (Reset_n && bus.ReadRegister1 != '0) begin
            if (bus.RegWrite1 && bus.WriteRegister1 == bus.ReadRegister1) begin
                bus.ReadData1 = bus.WriteData1;
                bus.ReadBusy1 = 1'b0;
            end else if (bus.RegWrite0 && bus.WriteRegister0 == bus.ReadRegister1) begin
                bus.ReadData1 = bus.WriteData0;
                bus.ReadBusy1 = 1'b0;
            end
        end
`endif
        if (bus.ReadRegister1 == '0) begin
            bus.ReadData1 = '0;
            bus.ReadBusy1 = 1'b0;
        end
    end

    // Read port 2: identical to port 1.
    always_comb begin
        bus.ReadData2 = regs[bus.ReadRegister2];
        bus.ReadBusy2 = busy[bus.ReadRegister2];
`ifdef REGFILE_BYPASS_EN
        if (Reset_n && bus.ReadRegister2 != '0) begin
            if (bus.RegWrite1 && bus.WriteRegister1 == bus.ReadRegister2) begin
                bus.ReadData2 = bus.WriteData1;
                bus.ReadBusy2 = 1'b0;
            end else if (bus.RegWrite0 && bus.WriteRegister0 == bus.ReadRegister2) begin
                bus.ReadData2 = bus.WriteData0;
                bus.ReadBusy2 = 1'b0;
            end
        end
`endif
        if (bus.ReadRegister2 == '0) begin
            bus.ReadData2 = '0;
            bus.ReadBusy2 = 1'b0;
        end
    end

    assign bus.ReserveStall = reserveStall;
    assign bus.BusyCount    = busyCount;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: the stimulus process computes the
// expected outputs from a plain array model and queues them; a negedge
// monitor pops and compares. Honours REGFILE_BYPASS_EN like the design.
module tb_regfile_scoreboard;
    localparam int WIDTH = 32;
    localparam int AB    = 5;
    localparam int DEPTH = 32;

    logic Clk = 1'b0;
    logic Reset_n;
    always #5 Clk = ~Clk;

    regfile_scoreboard_if #(.WIDTH(WIDTH), .ADDR_BITS(AB)) bus ();
    regfile_scoreboard #(.WIDTH(WIDTH), .ADDR_BITS(AB)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .bus(bus)
    );

    typedef struct {
        string       tag;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        rb1;
        logic        rb2;
        logic        stall;
        int          cnt;
    } expT;

    expT         scq[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] mReg  [DEPTH];
    bit          mBusy [DEPTH];

    function automatic void modelClear();
        for (int i = 0; i < DEPTH; i++) begin
            mReg[i]  = '0;
            mBusy[i] = 1'b0;
        end
    endfunction

    function automatic int modelCount();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) if (mBusy[i]) n++;
        return n;
    endfunction

    function automatic logic [31:0] expData(input int a);
        if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (Reset_n && bus.RegWrite1 && int'(bus.WriteRegister1) == a) return bus.WriteData1;
        if (Reset_n && bus.RegWrite0 && int'(bus.WriteRegister0) == a) return bus.WriteData0;
`endif
        return mReg[a];
    endfunction

    function automatic logic expBusy(input int a);
        if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (Reset_n && bus.RegWrite1 && int'(bus.WriteRegister1) == a) return 1'b0;
        if (Reset_n && bus.RegWrite0 && int'(bus.WriteRegister0) == a) return 1'b0;
`endif
        return mBusy[a];
    endfunction

    function automatic logic expStall();
        int  r   = int'(bus.ReserveRegister);
        bit  rel = (bus.RegWrite0 && int'(bus.WriteRegister0) == r) ||
                   (bus.RegWrite1 && int'(bus.WriteRegister1) == r);
        return bus.Reserve && mBusy[r] && !rel;
    endfunction

    // State change at a clock edge, in specification order.
    function automatic void modelEdge();
        int  r  = int'(bus.ReserveRegister);
        bit  st = expStall();
        if (bus.RegWrite0 && bus.WriteRegister0 != 0) begin
            mReg[bus.WriteRegister0]  = bus.WriteData0;
            mBusy[bus.WriteRegister0] = 1'b0;
        end
        if (bus.RegWrite1 && bus.WriteRegister1 != 0) begin
            mReg[bus.WriteRegister1]  = bus.WriteData1;
            mBusy[bus.WriteRegister1] = 1'b0;
        end
        if (bus.Reserve && !st && r != 0) mBusy[r] = 1'b1;
    endfunction

    function automatic void chk(input string tag, input string name,
                                input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s.%s got=%h want=%h at %0t", tag, name, got, exp, $time);
        end
    endfunction

    // Monitor: combinational outputs are stable by the falling edge.
    always @(negedge Clk) begin
        expT e;
        if (scq.size() > 0) begin
            e = scq.pop_front();
            chk(e.tag, "ReadData1", bus.ReadData1, e.rd1);
            chk(e.tag, "ReadData2", bus.ReadData2, e.rd2);
            chk(e.tag, "ReadBusy1", 32'(bus.ReadBusy1), 32'(e.rb1));
            chk(e.tag, "ReadBusy2", 32'(bus.ReadBusy2), 32'(e.rb2));
            chk(e.tag, "ReserveStall", 32'(bus.ReserveStall), 32'(e.stall));
            chk(e.tag, "BusyCount", 32'(bus.BusyCount), e.cnt);
        end
    end

    task automatic setIdle();
        bus.RegWrite0 = 1'b0; bus.RegWrite1 = 1'b0; bus.Reserve = 1'b0;
        bus.WriteRegister0 = '0; bus.WriteRegister1 = '0;
        bus.WriteData0 = '0; bus.WriteData1 = '0;
        bus.ReserveRegister = '0;
    endtask

    // One cycle: queue expectation for current inputs, then advance the model.
    task automatic step(input string tag);
        expT e;
        e.tag   = tag;
        e.rd1   = expData(int'(bus.ReadRegister1));
        e.rd2   = expData(int'(bus.ReadRegister2));
        e.rb1   = expBusy(int'(bus.ReadRegister1));
        e.rb2   = expBusy(int'(bus.ReadRegister2));
        e.stall = expStall();
        e.cnt   = modelCount();
        scq.push_back(e);
        @(posedge Clk);
        if (Reset_n) modelEdge();
        #1;
    endtask

    task automatic rd(input int a1, input int a2);
        bus.ReadRegister1 = AB'(a1);
        bus.ReadRegister2 = AB'(a2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset_n = 1'b0;
        setIdle();
        rd(0, 0);
        modelClear();
        @(posedge Clk); #1;
        step("por");
        Reset_n = 1'b1;
        step("idle");

        // write/read r5, write r0 discarded
        bus.RegWrite0 = 1; bus.WriteRegister0 = 5; bus.WriteData0 = 32'hDEADBEEF; rd(5, 0);
        step("wr5");
        setIdle(); step("rd5");
        bus.RegWrite0 = 1; bus.WriteRegister0 = 0; bus.WriteData0 = 32'hFFFFFFFF; rd(0, 5);
        step("wr0");
        setIdle(); step("rd0");

        // same-address dual write, port 1 wins
        bus.RegWrite0 = 1; bus.WriteRegister0 = 7; bus.WriteData0 = 32'h11;
        bus.RegWrite1 = 1; bus.WriteRegister1 = 7; bus.WriteData1 = 32'h22; rd(7, 5);
        step("dual7");
        setIdle(); step("rd7");

        // reserve / stall / release of r3
        bus.Reserve = 1; bus.ReserveRegister = 3; rd(3, 7);
        step("res3");
        step("res3again");
        setIdle(); bus.RegWrite0 = 1; bus.WriteRegister0 = 3; bus.WriteData0 = 32'h55;
        step("wr3");
        setIdle(); step("rd3");

        // reserve beats same-cycle release of r9
        bus.Reserve = 1; bus.ReserveRegister = 9; rd(9, 0);
        step("res9");
        bus.RegWrite1 = 1; bus.WriteRegister1 = 9; bus.WriteData1 = 32'h99;
        step("res9rel");
        setIdle(); step("rd9");

        // reserve of r0 is a no-op
        bus.Reserve = 1; bus.ReserveRegister = 0; rd(0, 9);
        step("res0");
        setIdle(); step("after0");

        // read-during-write of r4
        bus.RegWrite0 = 1; bus.WriteRegister0 = 4; bus.WriteData0 = 32'hA5A5A5A5; rd(4, 4);
        step("rdw4");
        setIdle(); step("rd4");

        // reset mid-operation with a write and reserve in flight
        bus.RegWrite0 = 1; bus.WriteRegister0 = 10; bus.WriteData0 = 32'h1234;
        bus.Reserve = 1; bus.ReserveRegister = 11; rd(5, 9);
        step("pre");
        bus.WriteRegister0 = 12; bus.ReserveRegister = 13;
        Reset_n = 1'b0; modelClear();
        step("midrst");
        Reset_n = 1'b1; setIdle(); rd(10, 12);
        step("postrst");
        rd(7, 13); step("postrst2");

        // randomized traffic over a small address window to force collisions
        for (int c = 0; c < 600; c++) begin
            bus.RegWrite0 = ($urandom_range(0, 9) < 4);
            bus.RegWrite1 = ($urandom_range(0, 9) < 3);
            bus.WriteRegister0 = AB'($urandom_range(0, 7));
            bus.WriteRegister1 = AB'($urandom_range(0, 7));
            bus.WriteData0 = $urandom;
            bus.WriteData1 = $urandom;
            bus.Reserve = ($urandom_range(0, 1) == 1);
            bus.ReserveRegister = AB'($urandom_range(0, 7));
            rd($urandom_range(0, 7), $urandom_range(0, 31));
            if (c == 300) begin
                Reset_n = 1'b0; modelClear();
                step("rndrst");
                Reset_n = 1'b1;
            end else begin
                step("rnd");
            end
        end

        setIdle(); rd(0, 0);
        step("final");
        @(negedge Clk); #1;
        total++;
        if (scq.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d want=0", scq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
